tmr_triplicating_reg: RTL and testbench

- Write-side counterpart of the multi-voter (mvtr).
- Holds one WIDTH-bit value as three register copies and drives them packed as {A,B,C}, ready to connect straight to an mvtr vtr_i.
- Votes its own copies internally every cycle and rewrites all three with the majority value (continuous scrubbing).
- Reports each detected disagreement on a one-cycle warning and a saturating error counter.
- Provides a fault-injection port so benches and system tests can upset a single copy.

---
 rtl/tmr_triplicating_reg.sv | 61 ++++++
 tb/tb_tmr_triplicating_reg.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tmr_triplicating_reg.sv
// tmr_triplicating_reg: triple-copy register with per-bit majority scrubbing, fault injection and mismatch reporting.
// Optional error counter enabled by defining TMR_ERR_CNT_EN; otherwise err_cnt_o is tied to zero.
module tmr_triplicating_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 inj_en_i,
  input  logic [1:0]           inj_sel_i,
  input  logic [WIDTH-1:0]     inj_mask_i,
  input  logic                 err_clr_i,
  output logic [3*WIDTH-1:0]   tmr_o,
  output logic [WIDTH-1:0]     data_o,
  output logic                 warn_o,
  output logic [CNT_W-1:0]     err_cnt_o
);
  logic [WIDTH-1:0] a_q, b_q, c_q, a_d, b_d, c_d, vote;
  logic mismatch, inj, warn_q;
  always_comb begin
    vote = (a_q & b_q) | (b_q & c_q) | (a_q & c_q);
    mismatch = (a_q != vote) || (b_q != vote) || (c_q != vote);
    inj = inj_en_i && (inj_sel_i != 2'd3);
    // injection holds the untouched copies so the upset stays visible for a cycle
    a_d = wr_en_i ? data_i : inj ? (inj_sel_i == 2'd0 ? a_q ^ inj_mask_i : a_q) : vote;
    b_d = wr_en_i ? data_i : inj ? (inj_sel_i == 2'd1 ? b_q ^ inj_mask_i : b_q) : vote;
    c_d = wr_en_i ? data_i : inj ? (inj_sel_i == 2'd2 ? c_q ^ inj_mask_i : c_q) : vote;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q <= RST_VAL;
      b_q <= RST_VAL;
      c_q <= RST_VAL;
      warn_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      warn_q <= mismatch;
    end
  end
  assign tmr_o  = {a_q, b_q, c_q};
  assign data_o = vote;
  assign warn_o = warn_q;
`ifdef TMR_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = err_clr_i ? '0 : (mismatch && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign err_cnt_o = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = err_clr_i;
  assign err_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tmr_triplicating_reg.sv
// tb_tmr_triplicating_reg: directed vector table plus hand sequences for saturation and async reset.
module tb_tmr_triplicating_reg;
`ifdef TMR_ERR_CNT_EN
  localparam bit CE = 1'b1;
`else
  localparam bit CE = 1'b0;
`endif
  logic clk = 1'b0, rst_i = 1'b1;
  logic wr_en_i = 0, inj_en_i = 0, err_clr_i = 0;
  logic [3:0] data_i = 0, inj_mask_i = 0;
  logic [1:0] inj_sel_i = 0;
  logic [11:0] tmr_o;
  logic [3:0] data_o;
  logic warn_o;
  logic [7:0] err_cnt_o;
  int passed = 0, total = 0;

  tmr_triplicating_reg #(.WIDTH(4), .CNT_W(8), .RST_VAL(4'b0000)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_en_i(wr_en_i), .data_i(data_i),
    .inj_en_i(inj_en_i), .inj_sel_i(inj_sel_i), .inj_mask_i(inj_mask_i),
    .err_clr_i(err_clr_i), .tmr_o(tmr_o), .data_o(data_o),
    .warn_o(warn_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr; logic [3:0] d; logic inj; logic [1:0] sel; logic [3:0] m; logic clr;
    logic [11:0] tmr; logic [3:0] q; logic w; logic [7:0] c;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic wr, input logic [3:0] d, input logic inj,
                       input logic [1:0] sel, input logic [3:0] m, input logic clr);
    @(negedge clk);
    wr_en_i = wr; data_i = d; inj_en_i = inj; inj_sel_i = sel; inj_mask_i = m; err_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // expected err_cnt values assume the counter is built; scaled by CE on compare
    for (int i = 0; i < 5; i++) vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'h000,4'h0,0,8'd0});
    vecs.push_back('{1,4'hE,0,2'd0,4'h0,0, 12'hEEE,4'hE,0,8'd0});
    vecs.push_back('{0,4'h0,1,2'd2,4'hE,0, 12'hEE0,4'hE,0,8'd0});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hEEE,4'hE,1,8'd1});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hEEE,4'hE,0,8'd1});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,1, 12'hEEE,4'hE,0,8'd0});
    vecs.push_back('{1,4'hF,1,2'd0,4'hF,0, 12'hFFF,4'hF,0,8'd0});
    vecs.push_back('{0,4'h0,1,2'd0,4'hF,0, 12'h0FF,4'hF,0,8'd0});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hFFF,4'hF,1,8'd1});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hFFF,4'hF,0,8'd1});
    vecs.push_back('{0,4'h0,1,2'd2,4'hF,0, 12'hFF0,4'hF,0,8'd1});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hFFF,4'hF,1,8'd2});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hFFF,4'hF,0,8'd2});
    vecs.push_back('{0,4'h0,1,2'd1,4'h1,0, 12'hFEF,4'hF,0,8'd2});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,1, 12'hFFF,4'hF,1,8'd0});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hFFF,4'hF,0,8'd0});
    vecs.push_back('{0,4'h0,1,2'd3,4'hF,0, 12'hFFF,4'hF,0,8'd0});
    vecs.push_back('{0,4'h0,1,2'd0,4'h1,0, 12'hEFF,4'hF,0,8'd0});
    vecs.push_back('{0,4'h0,1,2'd1,4'h1,0, 12'hEEF,4'hE,1,8'd1});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hEEE,4'hE,1,8'd2});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hEEE,4'hE,0,8'd2});
    vecs.push_back('{0,4'h0,1,2'd0,4'h1,0, 12'hFEE,4'hE,0,8'd2});
    vecs.push_back('{0,4'h0,1,2'd0,4'h1,0, 12'hEEE,4'hE,1,8'd3});
    vecs.push_back('{0,4'h0,1,2'd0,4'h1,0, 12'hFEE,4'hE,0,8'd3});
    vecs.push_back('{0,4'h0,1,2'd0,4'h1,0, 12'hEEE,4'hE,1,8'd4});
    vecs.push_back('{0,4'h0,0,2'd0,4'h0,0, 12'hEEE,4'hE,0,8'd4});

    #12;
    chk("rst_tmr", tmr_o, 12'h000);
    chk("rst_data", data_o, 4'h0);
    chk("rst_warn", warn_o, 1'b0);
    chk("rst_cnt", err_cnt_o, 8'd0);
    @(negedge clk);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].d, vecs[i].inj, vecs[i].sel, vecs[i].m, vecs[i].clr);
      chk($sformatf("v%0d_tmr", i), tmr_o, vecs[i].tmr);
      chk($sformatf("v%0d_data", i), data_o, vecs[i].q);
      chk($sformatf("v%0d_warn", i), warn_o, vecs[i].w);
      chk($sformatf("v%0d_cnt", i), err_cnt_o, CE ? vecs[i].c : 8'd0);
    end

    // saturation: each inject+idle pair adds exactly one mismatch cycle
    for (int i = 0; i < 260; i++) begin
      drive(0, 4'h0, 1, 2'd2, 4'h1, 0);
      drive(0, 4'h0, 0, 2'd0, 4'h0, 0);
      if (i % 64 == 0) chk($sformatf("sat%0d_warn", i), warn_o, 1'b1);
    end
    chk("sat_cnt", err_cnt_o, CE ? 8'd255 : 8'd0);
    drive(0, 4'h0, 1, 2'd2, 4'h1, 0);
    chk("sat_inj_tmr", tmr_o, 12'hEEF);
    drive(0, 4'h0, 0, 2'd0, 4'h0, 0);
    chk("sat_hold_cnt", err_cnt_o, CE ? 8'd255 : 8'd0);
    chk("sat_hold_warn", warn_o, 1'b1);
    chk("sat_hold_tmr", tmr_o, 12'hEEE);

    // asynchronous reset mid-cycle with an injection pending
    @(negedge clk);
    inj_en_i = 1; inj_sel_i = 2'd0; inj_mask_i = 4'hF; err_clr_i = 1;
    #2 rst_i = 1'b1;
    #1;
    chk("arst_tmr", tmr_o, 12'h000);
    chk("arst_data", data_o, 4'h0);
    chk("arst_cnt", err_cnt_o, 8'd0);
    chk("arst_warn", warn_o, 1'b0);
    drive(0, 4'h0, 0, 2'd0, 4'h0, 0);
    rst_i = 1'b0;
    drive(0, 4'h0, 0, 2'd0, 4'h0, 0);
    chk("post_rst_tmr", tmr_o, 12'h000);
    chk("post_rst_warn", warn_o, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
